// File: rtl/fft16_frame_loader.sv
// +-----------------------------------------------------------------------------+
// | Module      : fft16_frame_loader                                            |
// | Description : Streaming complex samples -> ping-pong 16-sample frames,      |
// |               presented as flat real/imag vectors for the 16-point FFT.     |
// |               Define FFT16_LOADER_BITREV_EN for bit-reversed slot order.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fft16_frame_loader #(
    parameter int DATA_WIDTH = 20,
    parameter int IN_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [IN_WIDTH-1:0]      s_real,
    input  logic [IN_WIDTH-1:0]      s_imag,
    input  logic                     s_last,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [DATA_WIDTH*16-1:0] frame_real_flat,
    output logic [DATA_WIDTH*16-1:0] frame_imag_flat,
    output logic                     frame_err
);

    localparam logic [3:0] c_LAST_IDX = 4'd15;

    logic [DATA_WIDTH-1:0] r_real [2][16];
    logic [DATA_WIDTH-1:0] r_imag [2][16];
    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [3:0]            r_wr_idx;
    logic                  r_frame_err;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_abort;
    logic                  w_consume;
    logic [3:0]            w_slot;
    logic [1:0]            w_full_next;
    logic [DATA_WIDTH-1:0] w_ext_real;
    logic [DATA_WIDTH-1:0] w_ext_imag;

    assign s_ready     = ~r_full[r_wr_bank];
    assign frame_valid = r_full[r_rd_bank];
    assign frame_err   = r_frame_err;

    assign w_accept   = s_valid & s_ready;
    assign w_complete = w_accept & (r_wr_idx == c_LAST_IDX);
    assign w_abort    = w_accept & s_last & (r_wr_idx != c_LAST_IDX);
    assign w_consume  = frame_valid & frame_ready;

    assign w_ext_real = DATA_WIDTH'($signed(s_real));
    assign w_ext_imag = DATA_WIDTH'($signed(s_imag));

`ifdef FFT16_LOADER_BITREV_EN
    // Decimation-in-time input order; frame bookkeeping stays in arrival order.
    assign w_slot = {r_wr_idx[0], r_wr_idx[1], r_wr_idx[2], r_wr_idx[3]};
`else
    assign w_slot = r_wr_idx;
`endif

    // Consume and completion never target the same bank, so both apply.
    always_comb begin
        w_full_next = r_full;
        if (w_consume) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_complete) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full      <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= 4'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_full      <= w_full_next;
            r_frame_err <= w_abort;
            if (w_consume) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_complete) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_abort) begin
                r_wr_idx <= 4'd0;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 16; s++) begin
                    r_real[b][s] <= '0;
                    r_imag[b][s] <= '0;
                end
            end
        end else if (w_accept) begin
            r_real[r_wr_bank][w_slot] <= w_ext_real;
            r_imag[r_wr_bank][w_slot] <= w_ext_imag;
        end
    end

    generate
        for (genvar k = 0; k < 16; k++) begin : g_flat
            assign frame_real_flat[DATA_WIDTH*k +: DATA_WIDTH] = r_real[r_rd_bank][k];
            assign frame_imag_flat[DATA_WIDTH*k +: DATA_WIDTH] = r_imag[r_rd_bank][k];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fft16_frame_loader.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_fft16_frame_loader                                         |
// | Description : Directed self-checking bench for fft16_frame_loader.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_fft16_frame_loader;

    localparam int DW = 20;
    localparam int IW = 16;

    logic           clk;
    logic           reset;
    logic           s_valid;
    logic           s_ready;
    logic [IW-1:0]  s_real;
    logic [IW-1:0]  s_imag;
    logic           s_last;
    logic           frame_valid;
    logic           frame_ready;
    logic [DW*16-1:0] frame_real_flat;
    logic [DW*16-1:0] frame_imag_flat;
    logic           frame_err;

    int vectors;
    int miscompares;

    fft16_frame_loader #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_real          (s_real),
        .s_imag          (s_imag),
        .s_last          (s_last),
        .frame_valid     (frame_valid),
        .frame_ready     (frame_ready),
        .frame_real_flat (frame_real_flat),
        .frame_imag_flat (frame_imag_flat),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] re_at(input int k);
        return frame_real_flat[DW*k +: DW];
    endfunction

    function automatic logic [DW-1:0] im_at(input int k);
        return frame_imag_flat[DW*k +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until accepted (bounded wait).
    task automatic push(input int re, input int im, input logic last);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_real  = IW'(re);
        s_imag  = IW'(im);
        s_last  = last;
        for (int c = 0; c < 50 && !done; c++) begin
            done = s_ready;
            tick();
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
        s_last = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_real      = '0;
        s_imag      = '0;
        s_last      = 1'b0;
        frame_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_flat_re", 32'(frame_real_flat[31:0] | frame_real_flat[DW*16-1 -: 32]), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single frame, consumed immediately
        frame_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("t1_s_ready", 32'(s_ready), 32'd1);
            push(k, -k, k == 15);
        end
        s_valid = 1'b0;
        check("t1_valid", 32'(frame_valid), 32'd1);
`ifdef FFT16_LOADER_BITREV_EN
        check("t1_slot8_re", 32'(re_at(8)), 32'h00001);
        check("t1_slot1_re", 32'(re_at(1)), 32'h00008);
        check("t1_slot15_re", 32'(re_at(15)), 32'h0000F);
        check("t1_slot3_im", 32'(im_at(3)), 32'hFFFF4);
`else
        check("t1_slot3_re", 32'(re_at(3)), 32'h00003);
        check("t1_slot3_im", 32'(im_at(3)), 32'hFFFFD);
        check("t1_slot15_re", 32'(re_at(15)), 32'h0000F);
`endif
        tick();
        check("t1_valid_gone", 32'(frame_valid), 32'd0);
        check("t1_no_err", 32'(frame_err), 32'd0);

        // 2: backpressure, two frames pending
        frame_ready = 1'b0;
        for (int n = 0; n < 32; n++) begin
            check("t2_ready_fill", 32'(s_ready), 32'd1);
            push(200 + n, n, 1'b0);
        end
        s_valid = 1'b1;
        s_real  = IW'(232);
        s_imag  = IW'(32);
        check("t2_ready_low", 32'(s_ready), 32'd0);
        check("t2_valid", 32'(frame_valid), 32'd1);
        tick();
        tick();
        check("t2_hold_ready", 32'(s_ready), 32'd0);
        check("t2_hold_slot0", 32'(re_at(0)), 32'd200);
        check("t2_hold_slot15", 32'(re_at(15)), 32'd215);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("t2_ready_back", 32'(s_ready), 32'd1);
        check("t2_next_valid", 32'(frame_valid), 32'd1);
        check("t2_f2_slot0", 32'(re_at(0)), 32'd216);
        check("t2_f2_slot15", 32'(re_at(15)), 32'd231);
        for (int n = 32; n < 40; n++) push(200 + n, n, 1'b0);
        frame_ready = 1'b1;
        for (int n = 40; n < 48; n++) push(200 + n, n, 1'b0);
        s_valid = 1'b0;
        check("t2_f3_valid", 32'(frame_valid), 32'd1);
        check("t2_f3_slot0", 32'(re_at(0)), 32'd232);
        check("t2_f3_slot15", 32'(re_at(15)), 32'd247);
        tick();
        check("t2_drained", 32'(frame_valid), 32'd0);

        // 3: alignment abort then a clean frame
        frame_ready = 1'b0;
        for (int n = 0; n < 6; n++) push(50 + n, 0, n == 5);
        s_valid = 1'b0;
        check("t3_err_pulse", 32'(frame_err), 32'd1);
        check("t3_no_valid", 32'(frame_valid), 32'd0);
        tick();
        check("t3_err_clear", 32'(frame_err), 32'd0);
        for (int n = 0; n < 16; n++) push(100 + n, 0, n == 15);
        s_valid = 1'b0;
        check("t3_valid", 32'(frame_valid), 32'd1);
        check("t3_slot0", 32'(re_at(0)), 32'd100);
        check("t3_slot15", 32'(re_at(15)), 32'd115);
`ifdef FFT16_LOADER_BITREV_EN
        check("t3_slot5", 32'(re_at(5)), 32'd110);
`else
        check("t3_slot5", 32'(re_at(5)), 32'd105);
`endif
        check("t3_no_err", 32'(frame_err), 32'd0);

        // 4: completion and consume on the same edge
        for (int n = 0; n < 16; n++) begin
            check("t4_ready", 32'(s_ready), 32'd1);
            frame_ready = (n == 15);
            push(300 + n, 0, 1'b0);
        end
        s_valid     = 1'b0;
        frame_ready = 1'b0;
        check("t4_valid", 32'(frame_valid), 32'd1);
        check("t4_slot0", 32'(re_at(0)), 32'd300);
        check("t4_slot15", 32'(re_at(15)), 32'd315);
        check("t4_ready_after", 32'(s_ready), 32'd1);

        // 5: reset mid-frame with a full bank pending
        for (int n = 0; n < 9; n++) push(400 + n, 0, 1'b0);
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check("t5_valid_rst", 32'(frame_valid), 32'd0);
        check("t5_ready_rst", 32'(s_ready), 32'd1);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 16; n++) push(500 + n, 0, 1'b0);
        s_valid = 1'b0;
        check("t5_valid", 32'(frame_valid), 32'd1);
        check("t5_slot0", 32'(re_at(0)), 32'd500);
        check("t5_slot15", 32'(re_at(15)), 32'd515);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
